sram_dbuf_ctrl: RTL
===================

# sram_dbuf_ctrl

Ping-pong controller and arbiter for the 64-bit double-buffered SRAM (`sram_w16_doubleBuffer_b64`).
- A producer streams whole tiles of DEPTH words into one bank while a consumer drains the other bank.
- The two banks share one address bus (A) and one data-in bus (D), so each cycle is either one write or one read.
- The controller arbitrates between the two sides, generates the active-low CEN/WEN strobes and addresses, and swaps bank roles when tiles complete.

## Interface
- `DEPTH`, 16, words per bank (one tile); power of two.
- `AW`, 4, address width, log2(DEPTH).
- `DW`, 64, data width.

- `CLK`  in  1  clock; rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr_valid`  in  1  producer has a word.
- `wr_data`  in  DW  producer word.
- `wr_ready`  out  1  write accepted this cycle when wr_valid & wr_ready.
- `rd_req`  in  1  consumer requests next word.
- `rd_ready`  out  1  read accepted this cycle when rd_req & rd_ready.
- `rd_valid`  out  1  rd_data valid (registered).
- `rd_data`  out  DW  equals SRAM Q; valid when rd_valid.
- `D`  out  DW  SRAM data in; equals wr_data.
- `A`  out  AW  SRAM address.
- `CEN_EVEN`, `WEN_EVEN`, `CEN_ODD`, `WEN_ODD`  out  1 each  SRAM strobes, active-low.
- `Q`  in  DW  SRAM data out.
- `full`  out  2  bit0 = even bank holds an unread or partly read tile; bit1 = odd bank.
- `wr_bank`, `rd_bank`  out  1 each  current fill and drain bank (0 = even).

## Operation
- State per bank: EMPTY, FULL. Registers:
  - wb, rb: bank select.
  - wptr, rptr: AW-bit pointers.
  - prio: 0 = write first.
  - rd_valid.
- Write eligible (we): `!full[wb]`. Read eligible (re): `full[rb]`.
- Grant, combinational:
  - Only one side requesting and eligible: that side wins.
  - Both `wr_valid & we` and `rd_req & re`: winner is write if prio==0, else read.
  - `wr_ready = we & !(read wins)`; `rd_ready = re & !(write wins)`.
- Write grant: CEN_x = WEN_x = 0 for x = wb; A = wptr; D = wr_data; other bank strobes = 1.
- Read grant: CEN_x = 0, WEN_x = 1 for x = rb; A = rptr.
- No grant: all CEN/WEN = 1; A = 0.
- Strobes and A are combinational from registered state and current requests. The SRAM samples them on the next CLK edge.
- On write grant edge:
  - wptr += 1, wrapping at DEPTH-1 → 0.
  - If wptr was DEPTH-1: full[wb] set, wb toggles.
- On read grant edge:
  - rptr += 1, wrapping.
  - If rptr was DEPTH-1: full[rb] cleared, rb toggles.
- prio toggles only on edges where both sides contended. The loser wins the next contention.
- Write and read can never complete in the same cycle (single grant). The EMPTY/FULL update is therefore race-free.
- Both banks FULL: wr_ready = 0 until the drain bank finishes its last read.
- Both EMPTY: rd_ready = 0.
- wb and rb start equal and stay consistent: the filled bank is always the next drained bank.

## Timing
- Reset (async, immediate):
  - wb = rb = 0, wptr = rptr = 0, full = 2'b00, prio = 0, rd_valid = 0.
  - All CEN/WEN = 1, A = 0, wr_ready = rd_ready = 0 while reset is high.
- First cycle after reset deasserts: wr_ready = 1 (combinationally gated by arbitration), rd_ready = 0.
- Write latency: word is in the SRAM at the grant edge. full/wb update at that same edge.
- Read latency: 1 cycle.
  - rd_valid is registered: set at the edge following a read grant, cleared otherwise.
  - rd_data = Q during the rd_valid cycle.
- Throughput:
  - Uncontended: 1 word/cycle per side.
  - Contended: writes and reads alternate, 1 word/2 cycles each.
- Tile swap has zero bubble: the write to addr 0 of the new wb may occur the cycle after the last write, if that bank is EMPTY.
- Reset mid-tile: all pointers and full flags are lost. Partial tiles are discarded; the SRAM contents are not cleared.

## Test plan
- **Reset:** assert reset mid-cycle.
  - Strobes go to 1 immediately.
  - After release: wr_ready = 1, rd_ready = 0, full = 00, wr_bank = rd_bank = 0.
- **Fill even:** wr_valid held high with data 0x...00 to 0x...0F for 16 cycles.
  - A = 0..15, CEN_EVEN = WEN_EVEN = 0, odd strobes = 1.
  - After the 16th edge: full = 01, wr_bank = 1.
- **Drain even:** rd_req held high for 16 cycles.
  - A = 0..15, CEN_EVEN = 0, WEN_EVEN = 1.
  - rd_valid is high one cycle later with rd_data = 0x...00 to 0x...0F in order.
  - Then full = 00, rd_bank = 1.
- **Contention:** even full, writing odd, wr_valid and rd_req both held high.
  - Grants alternate write, read, write, ..., starting with write (prio = 0).
  - 32 cycles complete both tiles; read data is correct.
- **Back-pressure:** fill both banks (32 writes) without reads.
  - wr_ready = 0 and full = 11.
  - A read of 16 words restores wr_ready = 1 the cycle after the last read edge, with wr_bank = 0.
- **Reset mid-fill:** reset after 5 writes into even.
  - full = 00, wptr = 0.
  - The next write goes to even bank addr 0.

Source files
------------

// File: rtl/sram_dbuf_ctrl.sv
// Ping-pong controller for a two-bank SRAM that shares one address/data bus.
// A producer fills one bank while a consumer drains the other, one access per cycle.
module sram_dbuf_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 64
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] D,
  output logic [AW-1:0] A,
  output logic          CEN_EVEN,
  output logic          WEN_EVEN,
  output logic          CEN_ODD,
  output logic          WEN_ODD,
  input  logic [DW-1:0] Q,
  output logic [1:0]    full,
  output logic          wr_bank,
  output logic          rd_bank
);

  typedef enum logic {BankEmpty, BankFull} bank_state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  logic          wb_q, wb_d, rb_q, rb_d;
  logic          prio_q, prio_d;
  logic          rd_valid_q;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          we, re, wr_go, rd_go, wr_win, rd_win;

  // Grants are forced off while reset is high so the strobes idle immediately.
  always_comb begin
    we     = (bank_q[wb_q] == BankEmpty);
    re     = (bank_q[rb_q] == BankFull);
    wr_go  = wr_valid & we & ~reset;
    rd_go  = rd_req & re & ~reset;
    wr_win = wr_go & (~rd_go | ~prio_q);
    rd_win = rd_go & (~wr_go | prio_q);
  end

  always_comb begin
    wr_ready = we & ~rd_win & ~reset;
    rd_ready = re & ~wr_win & ~reset;
    CEN_EVEN = 1'b1;
    WEN_EVEN = 1'b1;
    CEN_ODD  = 1'b1;
    WEN_ODD  = 1'b1;
    A        = '0;
    if (wr_win) begin
      A = wptr_q;
      if (wb_q) begin
        CEN_ODD = 1'b0;
        WEN_ODD = 1'b0;
      end else begin
        CEN_EVEN = 1'b0;
        WEN_EVEN = 1'b0;
      end
    end else if (rd_win) begin
      A = rptr_q;
      if (rb_q) CEN_ODD = 1'b0;
      else      CEN_EVEN = 1'b0;
    end
  end

  always_comb begin
    bank_d = bank_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    // Only a contended cycle flips priority, so the loser wins the next contention.
    prio_d = (wr_go & rd_go) ? ~prio_q : prio_q;
    if (wr_win) begin
      wptr_d = wptr_q + AW'(1);
      if (wptr_q == LastAddr) begin
        bank_d[wb_q] = BankFull;
        wb_d         = ~wb_q;
      end
    end
    if (rd_win) begin
      rptr_d = rptr_q + AW'(1);
      if (rptr_q == LastAddr) begin
        bank_d[rb_q] = BankEmpty;
        rb_d         = ~rb_q;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bank_q[0]  <= BankEmpty;
      bank_q[1]  <= BankEmpty;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      prio_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      prio_q     <= prio_d;
      rd_valid_q <= rd_win;
    end
  end

  assign full     = {bank_q[1] == BankFull, bank_q[0] == BankFull};
  assign wr_bank  = wb_q;
  assign rd_bank  = rb_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = Q;
  assign D        = wr_data;

endmodule
